// File: rtl/w_stream_pkg.sv
// Shared constants for the w_stream_gen serial pattern generator:
// FSM state encodings and default widths.
package w_stream_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int HIT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/w_stream_gen_if.sv
// Load channel of w_stream_gen: pattern, length and repeat flag with a
// valid/ready handshake.
interface w_stream_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
);
    // A load transfers on a rising clock edge where load_valid && load_ready.
    // The master holds load_valid and the payload stable until that edge;
    // a load offered while load_ready is low is neither accepted nor queued.
    logic             load_valid;
    logic             load_ready;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic             repeat_en;

    modport master (
        output load_valid, pattern, length, repeat_en,
        input  load_ready
    );

    modport slave (
        input  load_valid, pattern, length, repeat_en,
        output load_ready
    );
endinterface

// File: rtl/w_stream_gen_edge_hit_counter.sv
// Registers sig_in, detects rising edges and keeps a saturating tally of
// them. clr takes priority over a hit landing on the same edge.
module edge_hit_counter #(
    parameter int HIT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             sig_in,
    output logic [HIT_W-1:0] hits
);

    logic             sig_d, sig_q;
    logic [HIT_W-1:0] hits_d, hits_q;
    logic             hit;

    always_comb begin
        sig_d  = sig_in;
        hit    = sig_in && !sig_q;
        hits_d = hits_q;
        if (clr) begin
            hits_d = '0;
        end else if (hit && (hits_q != {HIT_W{1'b1}})) begin
            hits_d = hits_q + HIT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_q  <= 1'b0;
            hits_q <= '0;
        end else begin
            sig_q  <= sig_d;
            hits_q <= hits_d;
        end
    end

    assign hits = hits_q;

endmodule

// File: rtl/w_stream_gen.sv
// Serialises a loaded pattern MSB first onto w, optionally repeating with
// no gap, and tallies rising edges of the downstream counter's output.
module w_stream_gen
    import w_stream_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int HIT_W = HIT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    w_stream_gen_if.slave    ld,
    input  logic             stop,
    output logic             w,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state,
    input  logic             count_in,
    output logic [HIT_W-1:0] count_hits
);

    logic [1:0]       state_d, state_q;
    logic             w_d, w_q;
    logic             done_d, done_q;
    logic             rep_d, rep_q;
    logic [PAT_W-1:0] shreg_d, shreg_q;
    logic [PAT_W-1:0] saved_d, saved_q;
    logic [LEN_W-1:0] rem_d, rem_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic [LEN_W-1:0] eff_len;
    logic             accept;

    assign eff_len = (ld.length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : ld.length;
    // Zero-length loads are dropped without touching any state.
    assign accept  = ld.load_valid && (state_q == ST_IDLE) && (ld.length != '0);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        done_d  = done_q;
        rep_d   = rep_q;
        shreg_d = shreg_q;
        saved_d = saved_q;
        rem_d   = rem_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                w_d    = 1'b0;
                done_d = 1'b0;
                if (accept) begin
                    w_d     = ld.pattern[PAT_W-1];
                    shreg_d = ld.pattern << 1;
                    saved_d = ld.pattern;
                    rem_d   = eff_len - LEN_W'(1);
                    len_d   = eff_len;
                    rep_d   = ld.repeat_en;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (stop) begin
                    w_d     = 1'b0;
                    state_d = ST_IDLE;
                end else if (rem_q != '0) begin
                    w_d     = shreg_q[PAT_W-1];
                    shreg_d = shreg_q << 1;
                    rem_d   = rem_q - LEN_W'(1);
                end else if (rep_q) begin
                    w_d     = saved_q[PAT_W-1];
                    shreg_d = saved_q << 1;
                    rem_d   = len_q - LEN_W'(1);
                end else begin
                    w_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                w_d     = 1'b0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            w_q     <= 1'b0;
            done_q  <= 1'b0;
            rep_q   <= 1'b0;
            shreg_q <= '0;
            saved_q <= '0;
            rem_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            done_q  <= done_d;
            rep_q   <= rep_d;
            shreg_q <= shreg_d;
            saved_q <= saved_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
        end
    end

    edge_hit_counter #(.HIT_W(HIT_W)) u_hits (
        .clock  (clock),
        .reset  (reset),
        .clr    (accept),
        .sig_in (count_in),
        .hits   (count_hits)
    );

    assign ld.load_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign w             = w_q;
    assign done          = done_q;
    assign state         = state_q;

endmodule

// File: tb/tb_w_stream_gen.sv
// Directed bench for w_stream_gen: a vector table for single bursts plus
// hand-written repeat/stop, counter loop, async reset and saturation cases.
module tb_w_stream_gen;

  logic       clock;
  logic       reset;
  logic       stop;
  logic       w;
  logic       busy;
  logic       done;
  logic [1:0] state;
  logic       count_in;
  logic [7:0] count_hits;

  int checks;
  int failures;

  w_stream_gen_if #(.PAT_W(8), .LEN_W(4)) lif ();

  w_stream_gen #(.PAT_W(8), .LEN_W(4), .HIT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .ld         (lif),
    .stop       (stop),
    .w          (w),
    .busy       (busy),
    .done       (done),
    .state      (state),
    .count_in   (count_in),
    .count_hits (count_hits)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       lv;
    logic [7:0] pat;
    logic [3:0] len;
    logic       rep;
    logic       stp;
    logic       ci;
    logic       e_w;
    logic       e_done;
    logic [1:0] e_state;
    logic       e_ready;
    logic [7:0] e_hits;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [7:0] pat, input logic [3:0] len,
                       input logic rep, input logic stp, input logic ci);
    lif.load_valid = lv;
    lif.pattern    = pat;
    lif.length     = len;
    lif.repeat_en  = rep;
    stop           = stp;
    count_in       = ci;
  endtask

  function automatic vec_t mk(input logic lv, input logic [7:0] pat, input logic [3:0] len,
                              input logic ci, input logic stp, input logic ew, input logic ed,
                              input logic [1:0] es, input logic er, input logic [7:0] eh);
    vec_t v;
    v.lv = lv; v.pat = pat; v.len = len; v.rep = 1'b0; v.stp = stp; v.ci = ci;
    v.e_w = ew; v.e_done = ed; v.e_state = es; v.e_ready = er; v.e_hits = eh;
    return v;
  endfunction

  logic [4:0] rs_bits;
  int         run;
  int         ones;
  int         max_run;
  int         cur_run;
  logic       done_seen;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);

    // inputs applied before an edge, outputs expected after it
    //             lv   pat    len  ci   stp  w    done st  rdy  hits
    vecs[0]  = mk(1'b1, 8'hB0, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd0);
    vecs[1]  = mk(1'b0, 8'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1);
    vecs[2]  = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd1);
    vecs[3]  = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd1);
    vecs[4]  = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'd1);
    vecs[5]  = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    vecs[6]  = mk(1'b1, 8'hFF, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1);
    vecs[7]  = mk(1'b1, 8'hA5, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd0);
    vecs[8]  = mk(1'b1, 8'h00, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd0);
    vecs[9]  = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd0);
    vecs[10] = mk(1'b0, 8'h00, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1);
    vecs[11] = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1);
    vecs[12] = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd1);
    vecs[13] = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1);
    vecs[14] = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'd1);
    vecs[15] = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 8'd1);
    vecs[16] = mk(1'b0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1);

    // reset state
    repeat (2) @(negedge clock);
    check("rst w", w, 1'b0);
    check("rst done", done, 1'b0);
    check("rst state", state, 2'd0);
    check("rst ready", lif.load_ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst hits", count_hits, 8'd0);
    reset = 1'b0;

    // table: basic burst, zero length, clamped length, load while busy, hits
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].lv, vecs[i].pat, vecs[i].len, vecs[i].rep, vecs[i].stp, vecs[i].ci);
      @(negedge clock);
      check($sformatf("vec%0d w", i), w, vecs[i].e_w);
      check($sformatf("vec%0d done", i), done, vecs[i].e_done);
      check($sformatf("vec%0d state", i), state, vecs[i].e_state);
      check($sformatf("vec%0d ready", i), lif.load_ready, vecs[i].e_ready);
      check($sformatf("vec%0d busy", i), busy, vecs[i].e_state != 2'd0);
      check($sformatf("vec%0d hits", i), count_hits, vecs[i].e_hits);
    end
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);

    // repeat burst 110 110 ..., stop during the 5th bit
    rs_bits   = 5'b11011;
    done_seen = 1'b0;
    drive(1'b1, 8'hC0, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      lif.load_valid = 1'b0;
      check($sformatf("rep bit%0d", k), w, rs_bits[5 - k]);
      check($sformatf("rep state%0d", k), state, 2'd1);
      if (done) done_seen = 1'b1;
    end
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("stop w", w, 1'b0);
    check("stop state", state, 2'd0);
    if (done) done_seen = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (done) done_seen = 1'b1;
    end
    check("stop no done", done_seen, 1'b0);
    check("stop idle", state, 2'd0);

    // 7 ones into a stand-in counter that pulses count every 3rd high bit
    drive(1'b1, 8'hFF, 4'd7, 1'b0, 1'b0, 1'b0);
    run     = 0;
    ones    = 0;
    max_run = 0;
    cur_run = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      lif.load_valid = 1'b0;
      if (w) begin
        ones++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        run++;
      end else begin
        cur_run = 0;
        run     = 0;
      end
      count_in = (run != 0) && (run % 3 == 0);
    end
    count_in = 1'b0;
    @(negedge clock);
    check("ff ones", ones, 7);
    check("ff run", max_run, 7);
    check("ff hits", count_hits, 8'd2);
    check("ff idle", state, 2'd0);

    // asynchronous reset between edges, mid-burst
    drive(1'b1, 8'hFF, 4'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    lif.load_valid = 1'b0;
    count_in = 1'b1;
    @(negedge clock);
    count_in = 1'b0;
    check("pre rst hits", count_hits, 8'd1);
    check("pre rst w", w, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("arst w", w, 1'b0);
    check("arst state", state, 2'd0);
    check("arst done", done, 1'b0);
    check("arst hits", count_hits, 8'd0);
    check("arst ready", lif.load_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post rst w", w, 1'b0);
    check("post rst state", state, 2'd0);

    // saturation then accept with a coincident hit
    for (int i = 0; i < 300; i++) begin
      count_in = 1'b1;
      @(negedge clock);
      count_in = 1'b0;
      @(negedge clock);
    end
    check("sat hits", count_hits, 8'd255);
    drive(1'b1, 8'h80, 4'd1, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    check("clr hits", count_hits, 8'd0);
    check("clr w", w, 1'b1);
    check("clr state", state, 2'd1);
    @(negedge clock);
    check("len1 done", done, 1'b1);
    check("len1 state", state, 2'd2);
    @(negedge clock);
    check("len1 idle", state, 2'd0);
    check("len1 done low", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w_stream_gen.md
Name: w_stream_gen

Overview:
- Transmit-side companion to the lab `counter` FSM.
- Serialises a loaded bit pattern onto the single-bit `w` line, one bit per clock, MSB first, with optional continuous repeat.
- Monitors the counter's `count` output and tallies rising edges, so a bench or top level can close the loop: generator to counter to hit tally.

Parameters:
- PAT_W, 8: pattern register width (maximum bits per burst).
- LEN_W, 4: width of the length field; must hold values 0..PAT_W.
- HIT_W, 8: width of the saturating hit counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_valid  in  1  request to load pattern, length and repeat_en.
- load_ready  out  1  high when a load can be accepted (state IDLE).
- pattern  in  PAT_W  bits to send; pattern[PAT_W-1] is sent first.
- length  in  LEN_W  number of bits to send from the MSB down.
- repeat_en  in  1  sampled at load; 1 means restart the burst with no gap.
- stop  in  1  abort the burst.
- w  out  1  serial output, registered.
- busy  out  1  high in SHIFT or DONE.
- done  out  1  one-cycle pulse at the normal end of a non-repeat burst.
- state  out  2  current FSM state.
- count_in  in  1  `count` from the downstream counter.
- count_hits  out  HIT_W  number of count_in rising edges since the last accepted load.

Behaviour:
- Reset (asynchronous, immediate, also mid-burst): state=IDLE, w=0, done=0, count_hits=0, shift register, remaining, saved pattern and count_in delay flop all cleared. busy=0 and load_ready=1 follow from state.
- State encoding: IDLE=0, SHIFT=1, DONE=2; value 3 is illegal and recovers to IDLE on the next edge.
- Combinational outputs: load_ready = (state==IDLE); busy = (state!=IDLE).
- Load acceptance: occurs at an edge where load_valid && load_ready.
  - length==0: load is ignored; state stays IDLE; no done; count_hits is not cleared.
  - length>PAT_W: clamped to PAT_W.
- Accept edge (L = effective length):
  - w <= pattern[PAT_W-1]; shreg <= pattern<<1; saved <= pattern; remaining <= L-1; rep <= repeat_en; count_hits <= 0; state <= SHIFT.
  - The first bit appears on w in the cycle after the accept edge.
- SHIFT, each edge, in priority order:
  1. stop=1: w<=0; state<=IDLE; no done pulse.
  2. remaining!=0: w<=shreg[PAT_W-1]; shreg shifts left by 1; remaining decrements.
  3. remaining==0 and rep=1: reload from saved; w<=saved[PAT_W-1]; remaining<=L-1. No idle cycle between bursts.
  4. remaining==0 and rep=0: w<=0; done<=1; state<=DONE.
- Result: w carries exactly L pattern bits over L consecutive cycles, then returns to 0.
- DONE: one cycle only. Next edge sets done<=0 and state<=IDLE; stop has no effect in DONE.
- load_valid while not IDLE is ignored, not queued. The requester must hold it until load_ready.
- Hit counting:
  - count_in is registered once (c_d).
  - A hit is count_in && !c_d.
  - count_hits increments on a hit and saturates at 2^HIT_W-1.
  - A hit and an accept on the same edge: accept wins, count_hits=0.
  - Counting continues in all states.

Decomposition:
- Shared package `w_stream_pkg`:
  - state localparams ST_IDLE, ST_SHIFT, ST_DONE;
  - default PAT_W, LEN_W, HIT_W values.
- One sub-module, `edge_hit_counter`:
  - ports: clock, reset, clr, sig_in, hits;
  - contains the input register, rising-edge detect and saturating counter.
- FSM, shift register and length handling stay in `w_stream_gen`.

Test Plan:
- Reset, then pulse load_valid with pattern=8'b1011_0000, length=4, repeat_en=0 → w reads 1,0,1,1 on cycles 1-4 after the accept edge. Cycle 5: w=0, done=1, state=2. Cycle 6: state=0, load_ready=1.
- Load pattern=8'hFF, length=7, with w feeding the `counter` block → w high for exactly 7 cycles. count_hits equals the number of count rising edges, checked against a reference model of the counter.
- Load pattern=8'b1100_0000, length=3, repeat_en=1 → w sequence 1,1,0,1,1,0,... with no gaps. Assert stop on the 5th bit cycle → w=0 next cycle, state=IDLE, done never asserted.
- Load with length=0 → no state change, load_ready stays 1. Load with length=12 → exactly 8 bits sent. load_valid during SHIFT → ignored, pattern on w unchanged.
- Assert reset mid-burst (between clock edges) → w, done and count_hits go to 0 and state to IDLE immediately, without waiting for a clock edge.
- Drive count_in with 300 single-cycle pulses → count_hits saturates at 255. A new accept clears it to 0, including when a hit lands on the same edge.
